// File: rtl/sm83_serial_alu_if.sv
// ---------------------------------------------------------------------------
// sm83_serial_alu_if
// Request/response bundle between the decoder/sequencer and the byte-serial
// ALU.
//   master (sequencer): drives start, op, a, b, c_in; observes busy, done,
//                       res, f_out
//   slave  (ALU)      : the mirror image
// Signals:
//   start  request an operation (sampled on ce-enabled edges)
//   op     0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
//   a, b   WIDTH-bit operands; c_in incoming carry flag (ADC/SBC)
//   busy   operation in progress; done one-ce-cycle result-valid pulse
//   res    registered result; f_out registered flags {z,n,h,c}
// ---------------------------------------------------------------------------
interface sm83_serial_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic [3:0]       f_out;

    modport master (
        output start, op, a, b, c_in,
        input  busy, done, res, f_out
    );

    modport slave (
        input  start, op, a, b, c_in,
        output busy, done, res, f_out
    );
endinterface

// File: rtl/sm83_serial_alu.sv
// ---------------------------------------------------------------------------
// sm83_serial_alu
// Byte-serial ALU for multi-byte SM83 arithmetic (ADD HL,rr, ADD SP,e8 and
// wider). One SLICE-bit slice is processed per ce-enabled clock, LSB first,
// with the carry chained between slices. Flags {z,n,h,c} describe the full
// WIDTH-bit result; h is taken from the low nibble of the top slice.
// Ports:
//   clk   core clock
//   rst   asynchronous active-low reset
//   ce    clock enable; all state frozen while low
//   bus   sm83_serial_alu_if.slave (start/op/a/b/c_in in, busy/done/res/f_out out)
// Latency: done rises NSLICES ce-enabled edges after the accepting edge.
// ---------------------------------------------------------------------------
module sm83_serial_alu #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    sm83_serial_alu_if.slave   bus
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICES - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Carry seeded into slice 0; subtraction is a + ~b + 1 (minus borrow for SBC).
    function automatic logic init_carry(input logic [2:0] op, input logic c_in);
        case (op)
            OP_ADC:        init_carry = c_in;
            OP_SBC:        init_carry = ~c_in;
            OP_SUB, OP_CP: init_carry = 1'b1;
            default:       init_carry = 1'b0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       f_q, f_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    int               shamt_s;
    logic [SLICE-1:0] a_sl_s, b_sl_s, opnd_sl_s, slice_res_s;
    logic [SLICE:0]   sum_s;
    logic [4:0]       nib_s;
    logic             is_sub_s, is_logic_s;
    logic [WIDTH-1:0] full_res_s;
    logic [3:0]       flags_s;

    // Slice datapath: operand slice select, adder, logic ops and final flags.
    always_comb begin
        shamt_s     = int'(idx_q) * SLICE;
        a_sl_s      = SLICE'(a_q >> shamt_s);
        b_sl_s      = SLICE'(b_q >> shamt_s);
        is_sub_s    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
        is_logic_s  = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
        opnd_sl_s   = is_sub_s ? ~b_sl_s : b_sl_s;
        sum_s       = {1'b0, a_sl_s} + {1'b0, opnd_sl_s} + {{SLICE{1'b0}}, carry_q};
        // Only meaningful on the top slice, where it becomes the h flag.
        nib_s       = {1'b0, a_sl_s[3:0]} + {1'b0, opnd_sl_s[3:0]} + {4'b0000, carry_q};
        case (op_q)
            OP_AND:  slice_res_s = a_sl_s & b_sl_s;
            OP_XOR:  slice_res_s = a_sl_s ^ b_sl_s;
            OP_OR:   slice_res_s = a_sl_s | b_sl_s;
            default: slice_res_s = sum_s[SLICE-1:0];
        endcase
        // The accumulator is cleared on start, so OR-ing places the slice.
        full_res_s  = res_q | (WIDTH'(slice_res_s) << shamt_s);
        flags_s[3]  = (full_res_s == {WIDTH{1'b0}});
        flags_s[2]  = is_sub_s;
        if (is_logic_s) begin
            flags_s[1] = (op_q == OP_AND);
            flags_s[0] = 1'b0;
        end else begin
            flags_s[1] = is_sub_s ? ~nib_s[4] : nib_s[4];
            flags_s[0] = is_sub_s ? ~sum_s[SLICE] : sum_s[SLICE];
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        f_d     = f_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (ce) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        carry_d = init_carry(bus.op, bus.c_in);
                        res_d   = {WIDTH{1'b0}};
                        idx_d   = {IW{1'b0}};
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    carry_d = sum_s[SLICE];
                    if (idx_q == LAST_IDX) begin
                        // CP leaves the accumulator untouched; flags come from the subtraction.
                        res_d   = (op_q == OP_CP) ? a_q : full_res_s;
                        f_d     = flags_s;
                        idx_d   = {IW{1'b0}};
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        res_d   = full_res_s;
                        idx_d   = idx_q + IW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            carry_q <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            f_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            f_q     <= f_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res   = res_q;
    assign bus.f_out = f_q;

endmodule
